bless_inject_queue: RTL and testbench
=====================================

Name: bless_inject_queue

Overview:
- Node-side injection buffer for the bufferless router. It sits directly upstream of the router's port 4 (the injection port).
- It accepts flits (control + data) from the local node over a valid/ready handshake and stores them in a FIFO.
- It presents the head flit on port 4 and retires it on each clock edge where the router asserts port4_ready.
- It absorbs bursts while the router deflects traffic and the injection slot is unavailable.

Parameters:
- CW, 22, control word width; bit CW-1 is the flit-valid bit.
- DW, 128, data word width.
- DEPTH, 8, FIFO entries; must be a power of two, 2 or more.
- AW, 3, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  node offers a flit this cycle.
- in_ready  output  1  queue can accept a flit this cycle.
- in_c  input  CW  control word of the offered flit.
- in_d  input  DW  data word of the offered flit.
- port4_ready  input  1  router injection slot free this cycle.
- port4_co  output  CW  control word driven to the router's port4_ci.
- port4_do  output  DW  data word driven to the router's port4_di.
- count  output  AW+1  current occupancy, 0 to DEPTH.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous-to-clk release):
  - rd_ptr, wr_ptr and count go to 0.
  - in_ready = 1.
  - port4_co = 0 and port4_do = 0.
  - Storage contents are don't-care.
- push = in_valid & in_ready. in_ready = (count != DEPTH); it is registered-state only, with no combinational path from port4_ready.
- pop = (count != 0) & port4_ready.
- On push:
  - mem[wr_ptr] gets {1'b1, in_c[CW-2:0]}, in_d; the valid bit is forced to 1.
  - wr_ptr increments and wraps modulo DEPTH.
- On pop: rd_ptr increments and wraps modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- Output is combinational from the head entry:
  - count != 0: port4_co/port4_do = mem[rd_ptr].
  - count == 0: both outputs are 0, so the router sees an invalid flit (bit CW-1 = 0).
- Latency: a flit pushed at edge N appears on port4 after edge N. It can be injected at edge N+1 at the earliest. There is no empty-queue bypass.
- Ordering: strict FIFO; flits leave in the order accepted.
- Boundary conditions:
  - Full (count == DEPTH): in_ready = 0. An offered flit is not accepted, even if a pop occurs the same cycle.
  - Empty: port4_ready is ignored; nothing is popped; count stays 0.
  - Pointer wrap: DEPTH-1 wraps to 0 with no bubble.
  - port4_ready toggling while the head is held: the head stays stable until popped.
  - Reset mid-operation: all queued flits are discarded and outputs go to 0 immediately, asynchronously.

Optional Feature:
- Macro: INJQ_STATS_EN.
- When defined, two extra output ports are added:
  - inj_cnt  output  32: increments on every pop; wraps.
  - stall_cnt  output  16: increments each cycle count != 0 & !port4_ready; saturates at 16'hFFFF.
- Both counters reset to 0 on rst low.
- When not defined: the ports and counters do not exist, and the queue behaviour is identical.

Test Plan:
- Single flit:
  - Stimulus: after reset, push in_c = 22'h000001, in_d = 128'h0123456789abcdef0123456789abcdef, with port4_ready = 1.
  - Response: after the push edge, port4_co = 22'h200001 and count = 1. After the next edge, port4_co = 0 and count = 0.
- Fill to full:
  - Stimulus: port4_ready = 0; push 8 flits, then offer a 9th.
  - Response: count = 8 and in_ready = 0. The 9th flit is not stored, and the head is still flit 0.
- Simultaneous push and pop at full:
  - Stimulus: count = 8, in_valid = 1, port4_ready = 1.
  - Response: the pop occurs, the flit is not accepted, and count = 7. On the next cycle in_ready = 1.
- Wrap and order:
  - Stimulus: stream 20 flits with data = index 0..19 while port4_ready toggles 1,0,1,0.
  - Response: port4_do at each pop edge matches 0..19 in order, with no loss or duplication.
- Reset mid-operation:
  - Stimulus: with count = 5, drive rst low between clock edges.
  - Response: count = 0, port4_co = 0 and in_ready = 1 without waiting for a clock edge. After release, the first push appears at the head.
- Stats (INJQ_STATS_EN):
  - Stimulus: 3 flits queued, port4_ready low for 4 cycles, then high for 3.
  - Response: stall_cnt = 4, inj_cnt = 3.

Source files
------------

// File: rtl/bless_inject_queue.sv
// bless_inject_queue: FIFO injection buffer feeding router port 4; defining INJQ_STATS_EN adds inj_cnt/stall_cnt.
module bless_inject_queue #(
  parameter int CW    = 22,
  parameter int DW    = 128,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_c,
  input  logic [DW-1:0] in_d,
  input  logic          port4_ready,
  output logic [CW-1:0] port4_co,
  output logic [DW-1:0] port4_do,
  output logic [AW:0]   count
`ifdef INJQ_STATS_EN
  ,
  output logic [31:0]   inj_cnt,
  output logic [15:0]   stall_cnt
`endif
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [CW+DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop;
  assign in_ready = cnt_q != FULL;
  assign push = in_valid & in_ready;
  assign pop = (cnt_q != '0) & port4_ready;
  assign count = cnt_q;
  assign {port4_co, port4_do} = (cnt_q != '0) ? mem_q[rd_q] : '0;
  always_comb begin
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    cnt_d = (push & ~pop) ? cnt_q + 1'b1 : (~push & pop) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  // stored flits always carry the valid bit, whatever the node drove
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {in_c | {1'b1, {(CW-1){1'b0}}}, in_d};
`ifdef INJQ_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      inj_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) inj_cnt <= inj_cnt + 1'b1;
      if ((cnt_q != '0) && !port4_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_bless_inject_queue.sv
// tb_bless_inject_queue: scoreboard bench; driver queues expected flits, negedge monitor checks each pop.
module tb_bless_inject_queue;
  logic clk = 0, rst = 0, in_valid = 0, in_ready, port4_ready = 0;
  logic [21:0] in_c = '0, port4_co;
  logic [127:0] in_d = '0, port4_do;
  logic [3:0] count;
`ifdef INJQ_STATS_EN
  logic [31:0] inj_cnt;
  logic [15:0] stall_cnt;
  logic [31:0] inj0;
  logic [15:0] st0;
`endif
  int total = 0, bad = 0;
  logic [149:0] exp_q [$];

  bless_inject_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c), .in_d(in_d),
    .port4_ready(port4_ready), .port4_co(port4_co), .port4_do(port4_do), .count(count)
`ifdef INJQ_STATS_EN
    , .inj_cnt(inj_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [149:0] act, input logic [149:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst && port4_ready && count != 0) begin
      if (exp_q.size() == 0) chk("pop_unexpected", {port4_co, port4_do}, '0);
      else chk("pop_flit", {port4_co, port4_do}, exp_q.pop_front());
    end

  task automatic cyc(input logic v, input logic [21:0] c, input logic [127:0] d, input logic r, input logic acc);
    in_valid = v; in_c = c; in_d = d; port4_ready = r;
    if (acc) exp_q.push_back({1'b1, c[20:0], d});
    @(posedge clk); #1;
  endtask

  initial begin
    int idx, n;
    logic tog;
    #2;
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_co", port4_co, 0);
    chk("rst_do", port4_do, 0);
    @(posedge clk); #1 rst = 1;
    // single flit
    cyc(1, 22'h000001, 128'h0123456789abcdef0123456789abcdef, 1, 1);
    chk("single_co", port4_co, 22'h200001);
    chk("single_cnt", count, 1);
    cyc(0, 0, 0, 1, 0);
    chk("single_co_empty", port4_co, 0);
    chk("single_cnt_empty", count, 0);
    // empty queue ignores port4_ready
    cyc(0, 0, 0, 1, 0);
    chk("empty_cnt", count, 0);
    // fill to full, half the flits with the valid bit clear
    for (int i = 0; i < 8; i++)
      cyc(1, (i[0] ? 22'h200000 : 22'h0) | 22'(i + 16), 128'(i + 100), 0, 1);
    chk("full_cnt", count, 8);
    chk("full_ready", in_ready, 0);
    cyc(1, 22'h0000ff, 128'hdead, 0, 0);
    chk("full_cnt_hold", count, 8);
    chk("full_head_do", port4_do, 128'd100);
    chk("full_head_co", port4_co, 22'h200010);
    // push and pop at full: pop only
    cyc(1, 22'h0000ee, 128'hbeef, 1, 0);
    chk("fullpp_cnt", count, 7);
    chk("fullpp_ready", in_ready, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 0);
    chk("drain_cnt", count, 0);
    // wrap and order with toggling port4_ready
    idx = 0; n = 0; tog = 1;
    while ((idx < 20 || count != 0) && n < 200) begin
      if (idx < 20 && in_ready) begin
        cyc(1, 22'(idx), 128'(idx), tog, 1);
        idx++;
      end else cyc(0, 0, 0, tog, 0);
      tog = ~tog;
      n++;
    end
    chk("wrap_sent", 32'(idx), 20);
    chk("wrap_bounded", 32'(n < 200), 1);
    chk("wrap_sb_empty", 32'(exp_q.size()), 0);
    // reset mid-operation
    for (int i = 0; i < 5; i++) cyc(1, 22'(i + 40), 128'(i + 40), 0, 1);
    chk("mid_cnt5", count, 5);
    in_valid = 0;
    #2 rst = 0;
    #1;
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_co", port4_co, 0);
    chk("mid_rst_ready", in_ready, 1);
    exp_q.delete();
    #2 rst = 1;
    @(posedge clk); #1;
    cyc(1, 22'h000abc, 128'h55, 0, 1);
    chk("post_rst_co", port4_co, 22'h200abc);
    chk("post_rst_do", port4_do, 128'h55);
    cyc(0, 0, 0, 1, 0);
    chk("post_rst_drain", count, 0);
`ifdef INJQ_STATS_EN
    rst = 0;
    #2 rst = 1;
    @(posedge clk); #1;
    chk("stats_rst_inj", inj_cnt, 0);
    chk("stats_rst_stall", stall_cnt, 0);
    for (int i = 0; i < 3; i++) cyc(1, 22'(i), 128'(i + 7), 0, 1);
    inj0 = inj_cnt; st0 = stall_cnt;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    chk("stats_stall", stall_cnt - st0, 4);
    chk("stats_inj", inj_cnt - inj0, 3);
`endif
    cyc(0, 0, 0, 0, 0);
    chk("final_sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
